// File: rtl/hazard_control_unit.sv
// Hazard control: load-use stall, memory-busy freeze and taken-branch flush for the ID stage.
// Optional macro HAZARD_R0_ZERO_EN makes r0 hardwired zero, so loads to r0 never stall.
module hazard_control_unit #(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       IF_ID_rs,
    input  logic [2:0]       IF_ID_rt,
    input  logic             IF_ID_UseRs,
    input  logic             IF_ID_UseRt,
    input  logic [2:0]       ID_EXE_rd,
    input  logic             ID_EXE_MemRd,
    input  logic             ID_EXE_RegWr,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             PC_Wr,
    output logic             IF_ID_Wr,
    output logic             IF_ID_Flush,
    output logic             ID_EXE_Bubble,
    output logic             Pipe_Hold,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FREEZE  = 2'd2
    } state_t;

    localparam logic [3:0] LD_INIT = 4'(LOAD_STALL - 1);

    state_t            state_q, state_d;
    state_t            resume_q, resume_d;
    state_t            eff_state;
    logic [3:0]        ld_cnt_q, ld_cnt_d;
    logic              pending_flush_q, pending_flush_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic              rd_ok;
    logic              luse;
    logic              flush;

`ifdef HAZARD_R0_ZERO_EN
    assign rd_ok = |ID_EXE_rd;
`else
    assign rd_ok = 1'b1;
`endif

    assign luse = ID_EXE_MemRd & ID_EXE_RegWr & rd_ok &
                  ((IF_ID_UseRs & (ID_EXE_rd == IF_ID_rs)) |
                   (IF_ID_UseRt & (ID_EXE_rd == IF_ID_rt)));

    assign flush = branch_taken | pending_flush_q;

    // Leaving FREEZE acts as the remembered state within the same cycle.
    assign eff_state = (state_q == FREEZE) ? resume_q : state_q;

    always_comb begin
        state_d         = state_q;
        resume_d        = resume_q;
        ld_cnt_d        = ld_cnt_q;
        pending_flush_d = pending_flush_q;
        PC_Wr           = 1'b1;
        IF_ID_Wr        = 1'b1;
        IF_ID_Flush     = 1'b0;
        ID_EXE_Bubble   = 1'b0;
        Pipe_Hold       = 1'b0;

        if (mem_busy) begin
            Pipe_Hold = 1'b1;
            PC_Wr     = 1'b0;
            IF_ID_Wr  = 1'b0;
            state_d   = FREEZE;
            resume_d  = eff_state;
            if (branch_taken) begin
                pending_flush_d = 1'b1;
            end
        end else if (flush) begin
            IF_ID_Flush     = 1'b1;
            ID_EXE_Bubble   = 1'b1;
            pending_flush_d = 1'b0;
            ld_cnt_d        = 4'd0;
            state_d         = RUN;
        end else if (eff_state == LDSTALL) begin
            PC_Wr         = 1'b0;
            IF_ID_Wr      = 1'b0;
            ID_EXE_Bubble = 1'b1;
            ld_cnt_d      = ld_cnt_q - 4'd1;
            state_d       = (ld_cnt_q <= 4'd1) ? RUN : LDSTALL;
        end else if (luse) begin
            PC_Wr         = 1'b0;
            IF_ID_Wr      = 1'b0;
            ID_EXE_Bubble = 1'b1;
            if (LOAD_STALL > 1) begin
                ld_cnt_d = LD_INIT;
                state_d  = LDSTALL;
            end else begin
                state_d  = RUN;
            end
        end else begin
            state_d = RUN;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!PC_Wr && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= RUN;
            resume_q        <= RUN;
            ld_cnt_q        <= 4'd0;
            pending_flush_q <= 1'b0;
            stall_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            resume_q        <= resume_d;
            ld_cnt_q        <= ld_cnt_d;
            pending_flush_q <= pending_flush_d;
            stall_count_q   <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Producer-side companion to the pipeline's operand forwarding logic. It detects hazards that forwarding cannot cover: load-use, multi-cycle memory busy, and taken-branch wrong-path fetch.
- Drives PC/IF_ID write enables, IF_ID flush, the ID_EXE bubble and a whole-pipe hold.
- Sits beside the ID stage and consumes IF_ID, ID_EXE and EXE-stage control fields (3-bit register addresses, 8 registers).
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- LOAD_STALL, 1, cycles the ID instruction waits behind a load in EXE (range 1-15)
- CNT_W, 8, width of the stall-cycle counter

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- IF_ID_rs  input  3  source reg 1 of instruction in ID
- IF_ID_rt  input  3  source reg 2 of instruction in ID
- IF_ID_UseRs  input  1  ID instruction reads rs
- IF_ID_UseRt  input  1  ID instruction reads rt
- ID_EXE_rd  input  3  destination of instruction in EXE
- ID_EXE_MemRd  input  1  EXE instruction is a load
- ID_EXE_RegWr  input  1  EXE instruction writes register file
- branch_taken  input  1  taken branch resolved in EXE
- mem_busy  input  1  data memory not ready; pipe must freeze
- PC_Wr  output  1  PC update enable
- IF_ID_Wr  output  1  IF_ID register write enable
- IF_ID_Flush  output  1  clear IF_ID to NOP
- ID_EXE_Bubble  output  1  force ID_EXE control to NOP (RegWr=0, MemWr=0, MemRd=0)
- Pipe_Hold  output  1  hold ID_EXE, EXE_MEM, MEM_WB registers
- stall_count  output  CNT_W  cycles with PC_Wr=0, saturating

Behaviour:
- State register is {RUN, LDSTALL, FREEZE}, plus ld_cnt (4 bit) and pending_flush (1 bit). Outputs are combinational from state and inputs (Mealy).
- Reset (rst_n low, async): state=RUN, ld_cnt=0, pending_flush=0, stall_count=0. With idle inputs the outputs are PC_Wr=1, IF_ID_Wr=1 and all others 0.
- Definition: luse = ID_EXE_MemRd & ID_EXE_RegWr & ((IF_ID_UseRs & ID_EXE_rd==IF_ID_rs) | (IF_ID_UseRt & ID_EXE_rd==IF_ID_rt)).
- Priority: mem_busy > flush (branch_taken | pending_flush) > luse/LDSTALL.
- Any state, mem_busy=1:
  - Pipe_Hold=1, PC_Wr=0, IF_ID_Wr=0, IF_ID_Flush=0, ID_EXE_Bubble=0.
  - next state=FREEZE, with the prior state remembered (RUN or LDSTALL); ld_cnt frozen.
  - branch_taken=1 sets pending_flush.
- FREEZE, mem_busy=0: resume the remembered state this cycle and evaluate it normally.
- RUN, flush:
  - IF_ID_Flush=1, ID_EXE_Bubble=1, PC_Wr=1, IF_ID_Wr=1.
  - pending_flush cleared; luse ignored.
- RUN, luse, no flush:
  - PC_Wr=0, IF_ID_Wr=0, ID_EXE_Bubble=1.
  - If LOAD_STALL>1: ld_cnt=LOAD_STALL-1, next=LDSTALL; else stay RUN.
- LDSTALL:
  - PC_Wr=0, IF_ID_Wr=0, ID_EXE_Bubble=1; ld_cnt decrements.
  - At ld_cnt==1 the next state is RUN, and the stalled instruction issues on the following cycle.
- LDSTALL, flush: flush outputs as in RUN; ld_cnt=0, next=RUN. The stalled instruction is wrong-path.
- stall_count: +1 on each cycle with PC_Wr=0 and rst_n high; saturates at 2^CNT_W-1, no wrap.
- Same-register cases: luse checks rs and rt independently. Both matching the same rd gives one stall, not two.
- Non-load writers in EXE (ID_EXE_MemRd=0) never stall; forwarding covers them.
- Reset asserted mid-LDSTALL or mid-FREEZE: immediate return to RUN, pending_flush lost.

Optional Feature:
- Macro HAZARD_R0_ZERO_EN.
- Defined: register 0 is hardwired zero. Any compare where ID_EXE_rd==0 is forced false, so loads to r0 never stall.
- Undefined: r0 is an ordinary register and hazards on it stall normally.

Test Plan:
- Load-use, LOAD_STALL=1: ID_EXE_MemRd=1, RegWr=1, rd=3; IF_ID_rs=3, UseRs=1 -> exactly 1 cycle of PC_Wr=0, IF_ID_Wr=0, Bubble=1, then PC_Wr=1; stall_count=1.
- LOAD_STALL=3, rt match on rd=5 -> 3 consecutive stall cycles, state back to RUN, stall_count=3. UseRt=0 with the same rt -> no stall.
- Taken branch during LDSTALL (cycle 2 of 3) -> that cycle IF_ID_Flush=1, Bubble=1, PC_Wr=1; next cycle RUN, no further stall.
- mem_busy high 4 cycles with branch_taken pulsed in cycle 2 -> Pipe_Hold=1 and PC_Wr=0 for 4 cycles; cycle 5 IF_ID_Flush=1; stall_count +4.
- CNT_W=4, hold mem_busy 20 cycles -> stall_count sticks at 15.
- With HAZARD_R0_ZERO_EN, load rd=0 and rs=0 -> no stall. Without the macro -> 1-cycle stall. Assert rst_n=0 mid-FREEZE -> outputs return to reset values asynchronously.
